// File: rtl/ssd_mux_n.sv
// N-digit seven-segment multiplexer: refresh divider, anti-ghost blanking, glyph decode, frame-coherent loading.
// All outputs registered (1-cycle latency from counter state); no backpressure, load is a fire-and-forget strobe.
module ssd_mux_n #(
    parameter int NUM_DIGITS   = 2,
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 60,
    parameter int BLANK_CYCLES = 2,
    parameter int SIMULATE     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    lzb,
    input  logic                    load,
    input  logic [5*NUM_DIGITS-1:0] digits_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    ssd_c,
    output logic                    frame_done,
    output logic                    load_ack
);

    localparam int SLOT = (SIMULATE != 0) ? 4 : CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int TW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);

    generate
        if (SLOT <= BLANK_CYCLES) begin : g_bad_slot
            $error("ssd_mux_n: digit slot must be longer than BLANK_CYCLES");
        end
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("ssd_mux_n: NUM_DIGITS must be 2..8");
        end
    endgenerate

    logic [TW-1:0]              tick;
    logic [IW-1:0]              idx;
    logic [5*NUM_DIGITS-1:0]    pending;
    logic [5*NUM_DIGITS-1:0]    active;
    logic                       pend_flag;

    logic                       boundary;
    logic                       xfer;
    logic [4:0]                 cur_code;
    logic [NUM_DIGITS-1:0]      sup;
    logic [6:0]                 drive_seg;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'h00: glyph = 7'b1111110;
            5'h01: glyph = 7'b0110000;
            5'h02: glyph = 7'b1101101;
            5'h03: glyph = 7'b1111001;
            5'h04: glyph = 7'b0110011;
            5'h05: glyph = 7'b1011011;
            5'h06: glyph = 7'b1011111;
            5'h07: glyph = 7'b1110000;
            5'h08: glyph = 7'b1111111;
            5'h09: glyph = 7'b1111011;
            5'h0A: glyph = 7'b1110111;
            5'h0B: glyph = 7'b0011111;
            5'h0C: glyph = 7'b1001110;
            5'h0D: glyph = 7'b0111101;
            5'h0E: glyph = 7'b1001111;
            5'h0F: glyph = 7'b1000111;
            5'h11: glyph = 7'b0000001;
            5'h12: glyph = 7'b0110111;
            5'h13: glyph = 7'b0001110;
            5'h14: glyph = 7'b1100111;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    // A zero is suppressed only while every more-significant digit is zero or blank.
    always_comb begin : lz_blank
        logic       hi_empty;
        logic [4:0] code;
        sup      = '0;
        hi_empty = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            code   = active[5*k +: 5];
            sup[k] = lzb && (k != 0) && (code == 5'h00) && hi_empty;
            hi_empty = hi_empty && ((code == 5'h00) || (code == 5'h10));
        end
    end

    always_comb begin
        boundary  = (tick == TW'(SLOT - 1)) && (idx == IW'(NUM_DIGITS - 1));
        // With the display off there is no frame to wait for, so pending lands immediately.
        xfer      = pend_flag && (en ? boundary : 1'b1);
        cur_code  = active[idx*5 +: 5];
        drive_seg = 7'b0000000;
        if (tick >= TW'(BLANK_CYCLES) && !sup[idx])
            drive_seg = glyph(cur_code);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick       <= '0;
            idx        <= '0;
            seg        <= '0;
            dig_sel    <= '0;
            ssd_c      <= 1'b0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
            pending    <= '0;
            pend_flag  <= 1'b0;
            active     <= {NUM_DIGITS{5'h10}};
        end else begin
            frame_done <= en && boundary;
            load_ack   <= xfer;
            if (en) begin
                seg     <= drive_seg;
                dig_sel <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
                ssd_c   <= (idx == '0);
                if (tick == TW'(SLOT - 1)) begin
                    tick <= '0;
                    idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                end else begin
                    tick <= tick + 1'b1;
                end
            end else begin
                seg     <= '0;
                dig_sel <= '0;
                ssd_c   <= 1'b0;
                tick    <= '0;
                idx     <= '0;
            end
            if (xfer) begin
                active    <= pending;
                pend_flag <= 1'b0;
            end
            // A load on the transfer cycle re-arms the flag for the following frame.
            if (load) begin
                pending   <= digits_in;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_mux_n.sv
// Bench for ssd_mux_n: frame-position reference model feeds an expectation queue; a negedge monitor checks every cycle.
module tb_ssd_mux_n;

    localparam int N     = 4;
    localparam int SLOT  = 4;
    localparam int BLANK = 1;
    localparam int FRAME = N * SLOT;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           en = 1'b0;
    logic           lzb = 1'b0;
    logic           load = 1'b0;
    logic [5*N-1:0] digits_in = '0;
    logic [6:0]     seg;
    logic [N-1:0]   dig_sel;
    logic           ssd_c;
    logic           frame_done;
    logic           load_ack;

    ssd_mux_n #(
        .NUM_DIGITS  (N),
        .CLK_HZ      (100_000_000),
        .REFRESH_HZ  (60),
        .BLANK_CYCLES(BLANK),
        .SIMULATE    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .lzb        (lzb),
        .load       (load),
        .digits_in  (digits_in),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .ssd_c      (ssd_c),
        .frame_done (frame_done),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]   seg;
        logic [N-1:0] dig_sel;
        logic         ssd_c;
        logic         frame_done;
        logic         load_ack;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: position within the frame plus the displayed and queued character codes.
    int         m_pos;
    logic [4:0] m_act  [N];
    logic [4:0] m_pend [N];
    bit         m_pflag;

    localparam logic [6:0] HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] ref_glyph(input logic [4:0] c);
        if (c < 5'h10) return HEX[c[3:0]];
        case (c)
            5'h11:   return 7'b0000001;
            5'h12:   return 7'b0110111;
            5'h13:   return 7'b0001110;
            5'h14:   return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit lz_hidden(input int d);
        if (!lzb || d == 0 || m_act[d] != 5'h00) return 1'b0;
        for (int j = d + 1; j < N; j++)
            if (m_act[j] != 5'h00 && m_act[j] != 5'h10) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_pos   = 0;
        m_pflag = 1'b0;
        for (int k = 0; k < N; k++) begin
            m_act[k]  = 5'h10;
            m_pend[k] = 5'h00;
        end
    endtask

    initial m_reset();

    always @(posedge clk) begin : model_p
        obs_t e;
        bit   xfer;
        int   d;
        int   t;
        if (!reset) begin
            m_reset();
            exp_q.delete();
        end else begin
            e = '0;
            if (en) begin
                d = m_pos / SLOT;
                t = m_pos % SLOT;
                e.dig_sel[d] = 1'b1;
                e.ssd_c      = (d == 0);
                if (t >= BLANK && !lz_hidden(d)) e.seg = ref_glyph(m_act[d]);
                e.frame_done = (m_pos == FRAME - 1);
            end
            xfer       = m_pflag && (!en || m_pos == FRAME - 1);
            e.load_ack = xfer;
            exp_q.push_back(e);
            if (xfer) begin
                m_act   = m_pend;
                m_pflag = 1'b0;
            end
            if (load) begin
                for (int k = 0; k < N; k++) m_pend[k] = digits_in[5*k +: 5];
                m_pflag = 1'b1;
            end
            m_pos = en ? (m_pos + 1) % FRAME : 0;
        end
    end

    always @(negedge clk) begin : monitor_p
        obs_t e;
        obs_t a;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (!reset) e = '0;
        a = {seg, dig_sel, ssd_c, frame_done, load_ack};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL outputs @%0t: got seg=%b dig_sel=%b ssd_c=%b frame_done=%b load_ack=%b, want seg=%b dig_sel=%b ssd_c=%b frame_done=%b load_ack=%b",
                      $time, a.seg, a.dig_sel, a.ssd_c, a.frame_done, a.load_ack,
                      e.seg, e.dig_sel, e.ssd_c, e.frame_done, e.load_ack);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [4:0] d3, input logic [4:0] d2,
                           input logic [4:0] d1, input logic [4:0] d0);
        digits_in = {d3, d2, d1, d0};
        load      = 1'b1;
        step(1);
        load      = 1'b0;
    endtask

    task automatic wait_pos(input int p, input string name);
        for (int i = 0; i < 200; i++) begin
            if (en && m_pos == p) return;
            step(1);
        end
        n_checks++;
        $display("FAIL %s: frame position %0d not reached, last %0d", name, p, m_pos);
    endtask

    function automatic logic [4:0] rnd_code();
        case ($urandom_range(0, 3))
            0:       return 5'h00;
            1:       return 5'h10;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        step(3);
        reset = 1'b1;
        step(2);

        // Basic scan with digits 3,2,1,0 on d0..d3
        en = 1'b1;
        do_load(5'h0, 5'h1, 5'h2, 5'h3);
        step(40);

        // Leading-zero blanking on and off
        lzb = 1'b1;
        do_load(5'h00, 5'h00, 5'h05, 5'h00);
        step(36);
        lzb = 1'b0;
        step(20);

        // Second load before the boundary overwrites the first
        wait_pos(5, "pos_overwrite");
        do_load(5'hA, 5'hA, 5'hA, 5'hA);
        step(2);
        do_load(5'hB, 5'hB, 5'hB, 5'hB);
        step(40);

        // Load landing exactly on the boundary cycle
        wait_pos(3, "pos_pre_boundary");
        do_load(5'hC, 5'hC, 5'hC, 5'hC);
        wait_pos(FRAME - 1, "pos_boundary");
        do_load(5'hD, 5'hE, 5'hD, 5'hE);
        step(40);

        // Enable dropped at tick 2 of digit 1, then restored
        wait_pos(SLOT + 2, "pos_en_drop");
        en = 1'b0;
        step(5);
        en = 1'b1;
        step(20);

        // Load while disabled becomes active before re-enable
        en = 1'b0;
        step(2);
        do_load(5'h12, 5'h13, 5'h14, 5'h11);
        step(3);
        en = 1'b1;
        step(24);

        // Dash and out-of-range blank codes
        do_load(5'h1F, 5'h11, 5'h1F, 5'h11);
        step(40);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            en   = ($urandom_range(0, 15) != 0);
            lzb  = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 9) == 0);
            if (load) digits_in = {rnd_code(), rnd_code(), rnd_code(), rnd_code()};
            step(1);
            load = 1'b0;
        end

        // Mid-slot asynchronous reset with pending data in flight
        en  = 1'b1;
        lzb = 1'b0;
        wait_pos(6, "pos_reset");
        do_load(5'h8, 5'h8, 5'h8, 5'h8);
        step(1);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({seg, dig_sel, ssd_c, frame_done, load_ack} === '0) n_pass++;
        else $display("FAIL async_reset: got %b, want all zero",
                      {seg, dig_sel, ssd_c, frame_done, load_ack});
        step(2);
        reset = 1'b1;
        step(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
